ram_model: RTL and testbench
============================

RAM_MODEL -- requirements
Module: ram_model

Interface
REQ-001 Parameter LAT, default 2, number of BUSY cycles per access (0..15).
REQ-002 Parameter DEPTH, default 256, number of 32-bit words stored; word index = ramaddr[log2(DEPTH)+1:2].
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 nRST  input  1  asynchronous, active-low reset.
REQ-005 ramREN  input  1  read request, held by requester until ACCESS is seen.
REQ-006 ramWEN  input  1  write request, held by requester until ACCESS is seen.
REQ-007 ramaddr  input  32  byte address (word_t).
REQ-008 ramstore  input  32  write data (word_t), sampled at the edge that ends the ACCESS cycle.
REQ-009 ramload  output  32  read data (word_t).
REQ-010 ramstate  output  ramstate_t (cpu_types_pkg)  FREE, BUSY, ACCESS or ERROR; driven from a state register.

Function
REQ-011 A request is valid when exactly one of ramREN/ramWEN is high, ramaddr[1:0]==0 and the word index is < DEPTH.
REQ-012 A request is illegal under either of these conditions: (a) ramREN and ramWEN are both high; (b) one enable is high but ramaddr is misaligned or out of range.
REQ-013 State register reg_state, counter cnt (4 bits), latched address addr_q and latched op op_q (read/write) shall be kept; ramstate = reg_state.
REQ-014 Accept: on any edge where the next-state logic accepts a request, the block shall:
- latch addr_q/op_q;
- set cnt=LAT;
- go to BUSY if LAT>0, otherwise go to ACCESS.
REQ-015 FREE: illegal request -> ERROR; valid request -> accept; no request -> stay in FREE.
REQ-016 BUSY behaviour:
- illegal request -> ERROR;
- no request -> FREE (transaction abandoned, no write);
- valid request whose ramaddr or op differs from addr_q/op_q -> re-accept (counter restarts);
- otherwise, cnt==1 -> ACCESS, else decrement cnt.
REQ-017 ACCESS lasts exactly one cycle; at its ending edge, if op_q==write and ramWEN is still high, mem[addr_q] <= ramstore.
REQ-018 After ACCESS: illegal request -> ERROR; valid request -> accept (always treated as a new transaction, even for the same address); no request -> FREE.
REQ-019 ERROR: the next state is evaluated as from FREE, so ERROR persists while the request stays illegal.
REQ-020 ramload = mem[addr_q] while reg_state==ACCESS and op_q==read; otherwise ramload = 32'h0.
REQ-021 Back-to-back latency: a held valid request produces ACCESS every LAT+1 cycles (every cycle when LAT==0).
REQ-022 Writes never occur in FREE, BUSY or ERROR, nor for a read transaction.
REQ-023 When LAT==0 and a request is accepted in the same cycle as an address change, the new address is used for the access; no stale data is returned.

Reset
REQ-024 While nRST is low, the following shall hold asynchronously:
- reg_state=FREE, cnt=0, addr_q=0, op_q=read;
- ramload=0;
- all DEPTH memory words cleared to 0.
REQ-025 When nRST rises mid-transaction, that transaction is lost; a still-held request is accepted as new on the first edge after release.

Verification
REQ-026 Read latency, LAT=2: reset, then hold ramREN=1, ramaddr=0x10.
- Required: ramstate FREE, BUSY, BUSY, ACCESS (ramload=0x0), then BUSY again.
- Required: ramload=0 in all non-ACCESS cycles.
REQ-027 Write then read, LAT=2:
- Hold ramWEN=1, ramaddr=0x20, ramstore=0xDEADBEEF until ACCESS, then drop ramWEN.
- Then read 0x20: ACCESS cycle shows ramload=0xDEADBEEF.
- Read 0x24: ACCESS cycle shows 0x0.
REQ-028 Address change in BUSY, LAT=3:
- Read 0x40; in the 2nd BUSY cycle switch ramaddr to 0x44.
- Required: counter restarts; 3 further BUSY cycles, then ACCESS with ramload=mem[0x44].
REQ-029 Errors, each case followed by the stated response:
- ramREN=ramWEN=1 -> ERROR next cycle, held while both high; drop both -> FREE.
- ramaddr=0x22 with ramREN -> ERROR.
- ramaddr=4*DEPTH -> ERROR.
REQ-030 Abort: start a write to 0x30 (ramstore=0x1234); drop ramWEN during BUSY.
- Required: FREE next cycle; a later read of 0x30 returns 0x0.
REQ-031 LAT=0 and async reset:
- Held read gives ACCESS every cycle with ramload tracking ramaddr per cycle.
- Asserting nRST low mid-ACCESS forces ramstate=FREE and ramload=0 before the next edge.

Source files
------------

// File: rtl/ram_model_if.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg + ram_model_if
//
// Purpose:
//   Shared word/state types and the request/response bundle that connects a
//   memory requester to ram_model.
//
// Interface signals:
//   ramREN   - read request, held by the requester until ACCESS is seen
//   ramWEN   - write request, held by the requester until ACCESS is seen
//   ramaddr  - byte address
//   ramstore - write data, sampled on the edge that ends ACCESS
//   ramload  - read data, valid only during ACCESS of a read, zero otherwise
//   ramstate - FREE / BUSY / ACCESS / ERROR
//
// Modports:
//   master - requester side (drives requests, observes response)
//   slave  - memory side (observes requests, drives response)
// -----------------------------------------------------------------------------
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

interface ram_model_if;
  import cpu_types_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output ramREN,
    output ramWEN,
    output ramaddr,
    output ramstore,
    input  ramload,
    input  ramstate
  );

  modport slave (
    input  ramREN,
    input  ramWEN,
    input  ramaddr,
    input  ramstore,
    output ramload,
    output ramstate
  );
endinterface

// File: rtl/ram_model.sv
// -----------------------------------------------------------------------------
// ram_model
//
// Purpose:
//   Word-addressed RAM with a programmable number of wait states. A request is
//   accepted, spends LAT cycles in BUSY, then one cycle in ACCESS where read
//   data is presented or write data is committed. Misaligned, out-of-range or
//   read+write-at-once requests park the block in ERROR.
//
// Parameters:
//   LAT   - BUSY cycles per access (0..15)
//   DEPTH - number of 32-bit words
//
// Ports:
//   CLK  - clock, all state changes on the rising edge
//   nRST - asynchronous active-low reset (state, latches and memory cleared)
//   bus  - ram_model_if.slave request/response bundle
// -----------------------------------------------------------------------------
module ram_model
  import cpu_types_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 256
) (
  input  logic         CLK,
  input  logic         nRST,
  ram_model_if.slave   bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  ramstate_t     reg_state;
  ramstate_t     w_state_n;
  logic [3:0]    cnt;
  logic [3:0]    w_cnt_n;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] w_addr_n;
  op_t           op_q;
  op_t           w_op_n;
  word_t         mem [DEPTH];

  logic          w_req;
  logic          w_both;
  logic          w_aligned;
  logic          w_inrange;
  logic          w_valid;
  logic          w_illegal;
  logic          w_differs;
  logic          w_accept;
  logic          w_we;
  logic [AW-1:0] w_idx;
  op_t           w_op;

  // Request decode
  assign w_req     = bus.ramREN | bus.ramWEN;
  assign w_both    = bus.ramREN & bus.ramWEN;
  assign w_aligned = (bus.ramaddr[1:0] == 2'b00);
  // Whole word address is compared so non-power-of-two depths are range-checked
  assign w_inrange = ({2'b00, bus.ramaddr[31:2]} < 32'(DEPTH));
  assign w_valid   = w_req & ~w_both & w_aligned & w_inrange;
  assign w_illegal = w_both | (w_req & ~(w_aligned & w_inrange));
  assign w_idx     = bus.ramaddr[AW+1:2];
  assign w_op      = bus.ramWEN ? OP_WRITE : OP_READ;
  // Only meaningful for valid requests, where the index fully names the word
  assign w_differs = (w_idx != addr_q) || (w_op != op_q);

  // Next-state logic
  always_comb begin
    w_state_n = reg_state;
    w_cnt_n   = cnt;
    w_addr_n  = addr_q;
    w_op_n    = op_q;
    w_accept  = 1'b0;
    w_we      = 1'b0;

    case (reg_state)
      FREE, ERROR: begin
        if (w_illegal)    w_state_n = ERROR;
        else if (w_valid) w_accept  = 1'b1;
        else              w_state_n = FREE;
      end

      BUSY: begin
        if (w_illegal)      w_state_n = ERROR;
        else if (!w_req)    w_state_n = FREE;   // requester gave up, nothing written
        else if (w_differs) w_accept  = 1'b1;   // new target: restart the wait
        else if (cnt == 4'd1) begin
          w_state_n = ACCESS;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n   = cnt - 4'd1;
        end
      end

      ACCESS: begin
        // Write commits only if the requester is still asserting the write
        w_we = (op_q == OP_WRITE) && bus.ramWEN;
        if (w_illegal)    w_state_n = ERROR;
        else if (w_valid) w_accept  = 1'b1;     // always a fresh transaction
        else              w_state_n = FREE;
      end

      default: w_state_n = FREE;
    endcase

    if (w_accept) begin
      w_addr_n  = w_idx;
      w_op_n    = w_op;
      w_cnt_n   = 4'(LAT);
      w_state_n = (LAT > 0) ? BUSY : ACCESS;
    end
  end

  // Control registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      reg_state <= FREE;
      cnt       <= '0;
      addr_q    <= '0;
      op_q      <= OP_READ;
    end else begin
      reg_state <= w_state_n;
      cnt       <= w_cnt_n;
      addr_q    <= w_addr_n;
      op_q      <= w_op_n;
    end
  end

  // Storage array, cleared by reset so a reset also discards all contents
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (w_we) begin
      mem[addr_q] <= bus.ramstore;
    end
  end

  // Response
  assign bus.ramstate = reg_state;
  assign bus.ramload  = ((reg_state == ACCESS) && (op_q == OP_READ)) ? mem[addr_q] : '0;

endmodule

// File: tb/tb_ram_model.sv
module tb_ram_model;
  import cpu_types_pkg::*;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  ram_model_if bus0 ();
  ram_model_if bus2 ();
  ram_model_if bus3 ();

  ram_model #(.LAT(0), .DEPTH(256)) u_l0 (.CLK(CLK), .nRST(nRST), .bus(bus0));
  ram_model #(.LAT(2), .DEPTH(256)) u_l2 (.CLK(CLK), .nRST(nRST), .bus(bus2));
  ram_model #(.LAT(3), .DEPTH(256)) u_l3 (.CLK(CLK), .nRST(nRST), .bus(bus3));

  int    sel = 2;
  logic  ren = 1'b0;
  logic  wen = 1'b0;
  word_t addr  = '0;
  word_t store = '0;

  // Only the selected instance sees the stimulus; the others sit idle in FREE
  assign bus0.ramREN   = (sel == 0) ? ren : 1'b0;
  assign bus0.ramWEN   = (sel == 0) ? wen : 1'b0;
  assign bus0.ramaddr  = (sel == 0) ? addr : '0;
  assign bus0.ramstore = (sel == 0) ? store : '0;
  assign bus2.ramREN   = (sel == 2) ? ren : 1'b0;
  assign bus2.ramWEN   = (sel == 2) ? wen : 1'b0;
  assign bus2.ramaddr  = (sel == 2) ? addr : '0;
  assign bus2.ramstore = (sel == 2) ? store : '0;
  assign bus3.ramREN   = (sel == 3) ? ren : 1'b0;
  assign bus3.ramWEN   = (sel == 3) ? wen : 1'b0;
  assign bus3.ramaddr  = (sel == 3) ? addr : '0;
  assign bus3.ramstore = (sel == 3) ? store : '0;

  ramstate_t obs_state;
  word_t     obs_load;
  always_comb begin
    obs_state = bus2.ramstate;
    obs_load  = bus2.ramload;
    if (sel == 0) begin
      obs_state = bus0.ramstate;
      obs_load  = bus0.ramload;
    end else if (sel == 3) begin
      obs_state = bus3.ramstate;
      obs_load  = bus3.ramload;
    end
  end

  int    n_checks = 0;
  int    n_errors = 0;
  word_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic st(input string tag, input ramstate_t e);
    chk(tag, 32'(obs_state), 32'(e));
  endtask

  task automatic ld0(input string tag);
    chk(tag, obs_load, 32'h0);
  endtask

  // Advance until ACCESS (bounded), then compare ramload with the scoreboard
  task automatic wait_access(input string tag, input int max);
    bit found = 1'b0;
    for (int i = 0; i < max; i++) begin
      nxt();
      if (obs_state == ACCESS) begin
        found = 1'b1;
        break;
      end
      chk({tag, "_idle_load"}, obs_load, 32'h0);
    end
    chk({tag, "_reached_access"}, 32'(found), 32'd1);
    if (exp_q.size() == 0) chk({tag, "_scoreboard_size"}, 32'(exp_q.size()), 32'd1);
    else                   chk({tag, "_load"}, obs_load, exp_q.pop_front());
  endtask

  // Write held through the edge that ends ACCESS, dropped right after it
  task automatic write_word(input string tag, input word_t a, input word_t d, input int max);
    ren = 1'b0; wen = 1'b1; addr = a; store = d;
    exp_q.push_back(32'h0);
    wait_access(tag, max);
    nxt();
    wen = 1'b0;
    nxt();
    st({tag, "_free"}, FREE);
  endtask

  task automatic read_word(input string tag, input word_t a, input word_t e, input int max);
    wen = 1'b0; ren = 1'b1; addr = a;
    exp_q.push_back(e);
    wait_access(tag, max);
    ren = 1'b0;
    nxt();
    st({tag, "_free"}, FREE);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    word_t vals [3];
    vals[0] = 32'h1111_1111;
    vals[1] = 32'h2222_2222;
    vals[2] = 32'h3333_3333;

    // ---------------- reset, LAT=2 ----------------
    sel = 2;
    repeat (3) @(posedge CLK);
    st("reset_state", FREE);
    ld0("reset_load");
    #3 nRST = 1'b1;
    nxt();
    st("post_reset_state", FREE);

    // Held read at 0x10
    ren = 1'b1; addr = 32'h10;
    exp_q.push_back(32'h0);
    nxt(); st("r26_busy1", BUSY); ld0("r26_busy1_load");
    nxt(); st("r26_busy2", BUSY); ld0("r26_busy2_load");
    nxt(); st("r26_access", ACCESS);
    chk("r26_access_load", obs_load, exp_q.pop_front());
    nxt(); st("r26_busy_again", BUSY); ld0("r26_busy_again_load");
    ren = 1'b0;
    nxt(); st("r26_free", FREE);

    // Write then read back
    write_word("r27_wr20", 32'h20, 32'hDEAD_BEEF, 6);
    read_word("r27_rd20", 32'h20, 32'hDEAD_BEEF, 6);
    read_word("r27_rd24", 32'h24, 32'h0, 6);

    // Abandoned write
    wen = 1'b1; addr = 32'h30; store = 32'h1234;
    nxt(); st("r30_busy", BUSY);
    wen = 1'b0;
    nxt(); st("r30_free", FREE);
    read_word("r30_rd30", 32'h30, 32'h0, 6);

    // Error cases
    ren = 1'b1; wen = 1'b1; addr = 32'h10;
    nxt(); st("r29_both_err", ERROR);
    nxt(); st("r29_both_hold", ERROR);
    ren = 1'b0; wen = 1'b0;
    nxt(); st("r29_both_free", FREE);
    ren = 1'b1; addr = 32'h22;
    nxt(); st("r29_misalign_err", ERROR); ld0("r29_misalign_load");
    ren = 1'b0;
    nxt(); st("r29_misalign_free", FREE);
    ren = 1'b1; addr = 32'h400;
    nxt(); st("r29_range_err", ERROR);
    ren = 1'b0;
    nxt(); st("r29_range_free", FREE);
    ren = 1'b1; addr = 32'h10;
    nxt(); st("busy_illegal_busy", BUSY);
    wen = 1'b1;
    nxt(); st("busy_illegal_err", ERROR);
    wen = 1'b0; addr = 32'h20;
    nxt(); st("err_to_accept_busy", BUSY);
    ren = 1'b0;
    nxt(); st("err_to_accept_free", FREE);
    write_word("top_wr", 32'h3FC, 32'hA5A5_A5A5, 6);
    read_word("top_rd", 32'h3FC, 32'hA5A5_A5A5, 6);

    // ---------------- LAT=3 ----------------
    sel = 3;
    nxt(); st("l3_idle", FREE);
    write_word("r28_wr44", 32'h44, 32'hCAFE_0044, 8);
    ren = 1'b1; addr = 32'h40;
    nxt(); st("r28_busy1", BUSY);
    nxt(); st("r28_busy2", BUSY);
    addr = 32'h44;
    exp_q.push_back(32'hCAFE_0044);
    nxt(); st("r28_restart1", BUSY);
    nxt(); st("r28_restart2", BUSY);
    nxt(); st("r28_restart3", BUSY);
    nxt(); st("r28_access", ACCESS);
    chk("r28_access_load", obs_load, exp_q.pop_front());
    ren = 1'b0;
    nxt(); st("r28_free", FREE);

    // Write released before the ACCESS-ending edge must not commit
    wen = 1'b1; addr = 32'h48; store = 32'h55;
    exp_q.push_back(32'h0);
    wait_access("early_drop", 8);
    wen = 1'b0;
    nxt(); st("early_drop_free", FREE);
    read_word("early_drop_rd", 32'h48, 32'h0, 8);

    // ---------------- LAT=0 ----------------
    sel = 0;
    nxt(); st("l0_idle", FREE);
    for (int k = 0; k < 3; k++) write_word("l0_wr", word_t'(4 * k), vals[k], 3);
    ren = 1'b1;
    for (int k = 0; k < 6; k++) begin
      addr = word_t'(4 * (k % 3));
      exp_q.push_back(vals[k % 3]);
      nxt();
      st("r31_access_each", ACCESS);
      chk("r31_track_load", obs_load, exp_q.pop_front());
    end

    // Asynchronous reset in the middle of ACCESS
    #2 nRST = 1'b0;
    #1;
    st("r31_async_state", FREE);
    ld0("r31_async_load");
    @(posedge CLK);
    #3 nRST = 1'b1;
    addr = 32'h0;
    exp_q.push_back(32'h0);
    nxt();
    st("r25_reaccept", ACCESS);
    chk("r25_mem_cleared", obs_load, exp_q.pop_front());
    ren = 1'b0;
    nxt(); st("r25_free", FREE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
